// File: rtl/final_destination_engine.sv
// Fully connected NN inference sequencer: 2..5 layers, signed Q8.8, per-layer activation.
// Latency: sum over layers of nl(k)*(nl(k-1)+2) cycles from start to the done pulse.
// Backpressure: none; the weight ROM is combinational and results are pushed out unthrottled.
// Ports: start/no_layers/nlK/aflK configure a run (latched in IDLE); in_we/in_addr/in_data
//        load the input vector; w_addr/w_data stream weights; busy/done/error report status;
//        out_valid/out_idx/out_data stream the final-layer results.
module final_destination_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  no_layers,
  input  logic [5:0]  nl1,
  input  logic [5:0]  nl2,
  input  logic [5:0]  nl3,
  input  logic [5:0]  nl4,
  input  logic [5:0]  nl5,
  input  logic [1:0]  afl1,
  input  logic [1:0]  afl2,
  input  logic [1:0]  afl3,
  input  logic [1:0]  afl4,
  input  logic [1:0]  afl5,
  input  logic        in_we,
  input  logic [5:0]  in_addr,
  input  logic [15:0] in_data,
  output logic [15:0] w_addr,
  input  logic [15:0] w_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        out_valid,
  output logic [5:0]  out_idx,
  output logic [15:0] out_data
);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_ACT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [5:0]         cfg_layers;
  logic [5:0]         cfg_nl [0:7];
  logic [1:0]         cfg_af [0:7];
  logic [2:0]         lyr;
  logic [2:0]         lyr_prev;
  logic [5:0]         idx_i;
  logic [5:0]         idx_j;
  logic signed [39:0] acc;
  logic               err_q;

  // Ping-pong activation buffers; even layers read A, odd layers read B.
  logic [15:0] buf_a [0:63];
  logic [15:0] buf_b [0:63];

  logic               last_in;
  logic               last_nrn;
  logic               last_lyr;
  logic               cfg_bad;
  logic signed [15:0] x_cur;
  logic signed [31:0] prod;
  logic signed [39:0] sh;
  logic signed [15:0] ysat;
  logic signed [16:0] hs;
  logic [15:0]        y_act;

  assign lyr_prev = lyr - 3'd1;
  assign last_in  = (idx_i == cfg_nl[lyr_prev] - 6'd1);
  assign last_nrn = (idx_j == cfg_nl[lyr] - 6'd1);
  assign last_lyr = ({3'b000, lyr} == cfg_layers);
  assign cfg_bad  = (cfg_layers < 6'd2) || (cfg_layers > 6'd5) ||
                    (cfg_nl[1] == 6'd0) || (cfg_nl[2] == 6'd0) ||
                    ((cfg_layers >= 6'd3) && (cfg_nl[3] == 6'd0)) ||
                    ((cfg_layers >= 6'd4) && (cfg_nl[4] == 6'd0)) ||
                    ((cfg_layers >= 6'd5) && (cfg_nl[5] == 6'd0));
  assign x_cur    = lyr[0] ? buf_b[idx_i] : buf_a[idx_i];
  assign prod     = $signed(w_data) * x_cur;

  // Requantise to Q8.8 with saturation, then apply the layer activation.
  always_comb begin
    sh    = acc >>> 8;
    ysat  = sh[15:0];
    if (sh > 40'sd32767)
      ysat = 16'sh7FFF;
    else if (sh < -40'sd32768)
      ysat = 16'sh8000;
    hs    = ($signed({ysat[15], ysat}) >>> 2) + 17'sd128;
    y_act = ysat;
    case (cfg_af[lyr])
      2'b00: y_act = ysat[15] ? 16'h0000 : ysat;
      2'b01: y_act = ysat;
      2'b10: begin
        if (ysat > 16'sd256)
          y_act = 16'h0100;
        else if (ysat < -16'sd256)
          y_act = 16'hFF00;
        else
          y_act = ysat;
      end
      default: begin
        if (hs < 17'sd0)
          y_act = 16'h0000;
        else if (hs > 17'sd256)
          y_act = 16'h0100;
        else
          y_act = hs[15:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_BIAS;
      // The configuration check happens here, one cycle after start, so a bad
      // configuration never advances the weight address.
      S_BIAS: state_nxt = cfg_bad ? S_DONE : S_MAC;
      S_MAC:  if (last_in) state_nxt = S_ACT;
      S_ACT:  state_nxt = (last_nrn && last_lyr) ? S_DONE : S_BIAS;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy  = (state == S_BIAS) || (state == S_MAC) || (state == S_ACT);
  assign done  = (state == S_DONE);
  assign error = done && err_q;

  // w_addr always points at the word being read. It advances on leaving a read
  // cycle that has a successor read; during ACT it holds the last weight and
  // steps to the next bias on leaving ACT, so it stops on the final word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_layers <= '0;
      for (int k = 0; k < 8; k++) begin
        cfg_nl[k] <= '0;
        cfg_af[k] <= '0;
      end
      lyr       <= 3'd2;
      idx_i     <= '0;
      idx_j     <= '0;
      acc       <= '0;
      err_q     <= 1'b0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_layers <= no_layers;
            cfg_nl[1]  <= nl1;
            cfg_nl[2]  <= nl2;
            cfg_nl[3]  <= nl3;
            cfg_nl[4]  <= nl4;
            cfg_nl[5]  <= nl5;
            cfg_af[1]  <= afl1;
            cfg_af[2]  <= afl2;
            cfg_af[3]  <= afl3;
            cfg_af[4]  <= afl4;
            cfg_af[5]  <= afl5;
            lyr        <= 3'd2;
            idx_i      <= '0;
            idx_j      <= '0;
            err_q      <= 1'b0;
            w_addr     <= '0;
          end
        end
        S_BIAS: begin
          if (cfg_bad) begin
            err_q <= 1'b1;
          end else begin
            acc    <= {{16{w_data[15]}}, w_data, 8'h00};
            idx_i  <= '0;
            w_addr <= w_addr + 16'd1;
          end
        end
        S_MAC: begin
          acc <= acc + {{8{prod[31]}}, prod};
          if (!last_in) begin
            idx_i  <= idx_i + 6'd1;
            w_addr <= w_addr + 16'd1;
          end
        end
        S_ACT: begin
          if (last_lyr) begin
            out_valid <= 1'b1;
            out_idx   <= idx_j;
            out_data  <= y_act;
          end
          if (!(last_nrn && last_lyr))
            w_addr <= w_addr + 16'd1;
          if (last_nrn) begin
            lyr   <= lyr + 3'd1;
            idx_j <= '0;
          end else begin
            idx_j <= idx_j + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer storage carries no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_we)
      buf_a[in_addr] <= in_data;
    if (state == S_ACT) begin
      if (lyr[0])
        buf_a[idx_j] <= y_act;
      else
        buf_b[idx_j] <= y_act;
    end
  end

endmodule

// File: tb/tb_final_destination_engine.sv
module tb_final_destination_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  no_layers, nl1, nl2, nl3, nl4, nl5;
  logic [1:0]  afl1, afl2, afl3, afl4, afl5;
  logic        in_we = 1'b0;
  logic [5:0]  in_addr = '0;
  logic [15:0] in_data = '0;
  logic [15:0] w_addr, w_data;
  logic        busy, done, error, out_valid;
  logic [5:0]  out_idx;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  logic [15:0] rom [0:8191];
  assign w_data = rom[w_addr[12:0]];

  final_destination_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .no_layers(no_layers),
    .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4), .nl5(nl5),
    .afl1(afl1), .afl2(afl2), .afl3(afl3), .afl4(afl4), .afl5(afl5),
    .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data), .busy(busy), .done(done), .error(error),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Test configuration
  int          c_nlay;
  int          c_nl [1:5];
  int          c_af [1:5];
  logic [15:0] vec  [0:63];

  // Reference model results
  logic [15:0] exp_out [0:63];
  int          exp_ovk [0:63];
  int          exp_n, exp_nov, exp_wmax;
  bit          exp_bad;

  // Observations from the latest run
  int          ov_k [0:63];
  logic [5:0]  ov_i [0:63];
  logic [15:0] ov_d [0:63];
  int          done_k, n_ov, wmax;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Evaluates the network in plain integer arithmetic, walking the ROM in
  // bias-then-weights order, and derives the expected timing.
  function automatic void model();
    longint x [0:63];
    longint y [0:63];
    longint acc, v;
    int p, n, np, nc;
    exp_bad = (c_nlay < 2) || (c_nlay > 5);
    if (!exp_bad)
      for (int k = 1; k <= c_nlay; k++) if (c_nl[k] == 0) exp_bad = 1;
    if (exp_bad) begin
      exp_n = 1; exp_nov = 0; exp_wmax = 0;
      return;
    end
    for (int i = 0; i < 64; i++) begin
      x[i] = longint'($signed(vec[i]));
      y[i] = 0;
    end
    p = 0; n = 0; np = 0; nc = 0;
    for (int L = 2; L <= c_nlay; L++) begin
      np = c_nl[L-1];
      nc = c_nl[L];
      for (int j = 0; j < nc; j++) begin
        acc = longint'($signed(rom[p])) * 256;
        p++;
        for (int i = 0; i < np; i++) begin
          acc = acc + longint'($signed(rom[p])) * x[i];
          p++;
        end
        v = clamp(fdiv(acc, 256), -32768, 32767);
        case (c_af[L])
          0: if (v < 0) v = 0;
          1: ;
          2: v = clamp(v, -256, 256);
          default: v = clamp(fdiv(v, 4) + 128, 0, 256);
        endcase
        y[j] = v;
        if (L == c_nlay) exp_out[j] = 16'(v);
        n += np + 2;
      end
      for (int i = 0; i < 64; i++) x[i] = y[i];
    end
    exp_n = n; exp_nov = nc; exp_wmax = p - 1;
    for (int j = 0; j < nc; j++) exp_ovk[j] = n - nc * (np + 2) + (j + 1) * (np + 2);
  endfunction

  task automatic fill_rom(input logic [15:0] b, input logic [15:0] w2, input logic [15:0] wr);
    int p;
    p = 0;
    for (int L = 2; L <= c_nlay; L++)
      for (int j = 0; j < c_nl[L]; j++) begin
        rom[p] = b; p++;
        for (int i = 0; i < c_nl[L-1]; i++) begin
          rom[p] = (L == 2) ? w2 : wr; p++;
        end
      end
  endtask

  task automatic set_cfg(input int nlay, input int a, input int b, input int c, input int d,
                         input int e, input int af);
    c_nlay = nlay;
    c_nl[1] = a; c_nl[2] = b; c_nl[3] = c; c_nl[4] = d; c_nl[5] = e;
    for (int k = 1; k <= 5; k++) c_af[k] = af;
  endtask

  // Loads the input vector, drives the config and pulses start; returns just after E0.
  task automatic launch();
    for (int i = 0; i < c_nl[1] && i < 64; i++) begin
      in_we = 1'b1; in_addr = 6'(i); in_data = vec[i];
      @(posedge clk); #1;
    end
    in_we = 1'b0;
    no_layers = 6'(c_nlay);
    nl1 = 6'(c_nl[1]); nl2 = 6'(c_nl[2]); nl3 = 6'(c_nl[3]); nl4 = 6'(c_nl[4]); nl5 = 6'(c_nl[5]);
    afl1 = 2'(c_af[1]); afl2 = 2'(c_af[2]); afl3 = 2'(c_af[3]); afl4 = 2'(c_af[4]); afl5 = 2'(c_af[5]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_case(input string nm, input int restart_k);
    int k;
    bit busy_bad, err_bad, err_at_done;
    model();
    launch();
    k = 0; done_k = -1; n_ov = 0; wmax = 0;
    busy_bad = 0; err_bad = 0; err_at_done = 0;
    while (k <= exp_n + 20) begin
      if (busy !== ((k < exp_n) ? 1'b1 : 1'b0)) busy_bad = 1;
      if (int'(w_addr) > wmax) wmax = int'(w_addr);
      if (out_valid === 1'b1) begin
        if (n_ov < 64) begin
          ov_k[n_ov] = k; ov_i[n_ov] = out_idx; ov_d[n_ov] = out_data;
        end
        n_ov++;
      end
      if (done === 1'b1) begin
        done_k = k; err_at_done = error;
        break;
      end
      if (error !== 1'b0) err_bad = 1;
      start = (k + 1 == restart_k) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check({nm, "/done_cycle"}, done_k, exp_n);
    check({nm, "/error"}, err_at_done, exp_bad);
    check({nm, "/busy_profile"}, busy_bad, 0);
    check({nm, "/stray_error"}, err_bad, 0);
    check({nm, "/n_out"}, n_ov, exp_nov);
    for (int j = 0; j < exp_nov && j < n_ov && j < 64; j++) begin
      check({nm, "/out_idx"}, ov_i[j], j);
      check({nm, "/out_data"}, ov_d[j], exp_out[j]);
      check({nm, "/out_cycle"}, ov_k[j], exp_ovk[j]);
    end
    check({nm, "/w_addr_max"}, wmax, exp_wmax);
    @(posedge clk); #1;
    check({nm, "/idle_done"}, done, 1'b0);
    check({nm, "/idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    bit bad_flag;
    logic [15:0] t;
    no_layers = '0; nl1 = '0; nl2 = '0; nl3 = '0; nl4 = '0; nl5 = '0;
    afl1 = '0; afl2 = '0; afl3 = '0; afl4 = '0; afl5 = '0;
    for (int a = 0; a < 8192; a++) rom[a] = '0;
    for (int i = 0; i < 64; i++) vec[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", busy, 1'b0);
    check("rst/done", done, 1'b0);
    check("rst/error", error, 1'b0);
    check("rst/out_valid", out_valid, 1'b0);
    check("rst/out_idx", out_idx, 6'd0);
    check("rst/out_data", out_data, 16'd0);
    check("rst/w_addr", w_addr, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 4-2-3 ReLU network
    set_cfg(3, 4, 2, 3, 1, 1, 0);
    for (int i = 0; i < 64; i++) vec[i] = 16'h0100;
    fill_rom(16'h0000, 16'h0080, 16'h0080);
    run_case("tp1", 0);
    check("tp1/latency24", done_k, 24);
    check("tp1/w_addr18", wmax, 18);
    for (int j = 0; j < 3; j++) check("tp1/out_0200", ov_d[j], 16'h0200);

    // Negative layer-2 weights through ReLU
    fill_rom(16'h0000, 16'hFF80, 16'h0080);
    run_case("relu_zero", 0);
    check("relu_zero/out", ov_d[0], 16'h0000);
    fill_rom(16'h0100, 16'hFF80, 16'h0080);
    c_af[3] = 1;
    run_case("relu_bias", 0);
    check("relu_bias/out", ov_d[2], 16'h0100);

    // Saturation and clamping
    set_cfg(2, 2, 1, 1, 1, 1, 1);
    for (int i = 0; i < 64; i++) vec[i] = 16'h7F00;
    fill_rom(16'h0000, 16'h7F00, 16'h7F00);
    run_case("sat_id", 0);
    check("sat_id/out", ov_d[0], 16'h7FFF);
    c_af[2] = 2;
    run_case("sat_tanh", 0);
    check("sat_tanh/out", ov_d[0], 16'h0100);
    c_af[2] = 3;
    for (int i = 0; i < 64; i++) vec[i] = 16'h0000;
    run_case("hsig_zero", 0);
    check("hsig_zero/out", ov_d[0], 16'h0080);

    // Invalid configurations
    set_cfg(1, 4, 2, 3, 1, 1, 0);
    run_case("inv_nlay1", 0);
    set_cfg(3, 4, 0, 3, 1, 1, 0);
    run_case("inv_nl2", 0);
    set_cfg(6, 2, 2, 2, 2, 2, 0);
    run_case("inv_nlay6", 0);

    // Start pulse during a run is ignored
    set_cfg(3, 4, 2, 3, 1, 1, 0);
    for (int i = 0; i < 64; i++) vec[i] = 16'h0100;
    fill_rom(16'h0000, 16'h0080, 16'h0080);
    run_case("restart", 5);
    check("restart/latency24", done_k, 24);
    check("restart/out", ov_d[1], 16'h0200);

    // Reset in the middle of MAC
    launch();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst/busy", busy, 1'b0);
    check("midrst/out_valid", out_valid, 1'b0);
    check("midrst/w_addr", w_addr, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad_flag = 0;
    for (int c = 0; c < 30; c++) begin
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad_flag = 1;
      @(posedge clk); #1;
    end
    check("midrst/quiet", bad_flag, 0);
    run_case("after_rst", 0);

    // Randomised networks
    for (int r = 0; r < 6; r++) begin
      c_nlay = $urandom_range(2, 5);
      for (int k = 1; k <= 5; k++) begin
        c_nl[k] = $urandom_range(1, 8);
        c_af[k] = $urandom_range(0, 3);
      end
      for (int a = 0; a < 8192; a++) begin
        t = 16'($urandom);
        if (r % 2 == 0) t = {{6{t[9]}}, t[9:0]};
        rom[a] = t;
      end
      for (int i = 0; i < 64; i++) begin
        t = 16'($urandom);
        if (r % 3 != 2) t = {{5{t[10]}}, t[10:0]};
        vec[i] = t;
      end
      run_case($sformatf("rand%0d", r), 0);
    end

    // Widest layers
    set_cfg(3, 63, 63, 2, 1, 1, 1);
    c_af[2] = 2;
    for (int a = 0; a < 8192; a++) begin
      t = 16'($urandom);
      rom[a] = {{8{t[7]}}, t[7:0]};
    end
    for (int i = 0; i < 64; i++) begin
      t = 16'($urandom);
      vec[i] = {{7{t[8]}}, t[8:0]};
    end
    run_case("wide63", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
